// File: rtl/upscale_pkg.sv
// -----------------------------------------------------------------------------
// upscale_pkg
// Shared types, widths and helpers for the upscale frame-timing scheduler.
//   fetch_state_t  : kernel fetch FSM states
//   HCOUNT_W       : raster x width
//   VCOUNT_W       : raster y width
//   is_fetch_line  : true on raster lines that start a KxK band fetch
// -----------------------------------------------------------------------------
package upscale_pkg;

   localparam int unsigned HCOUNT_W = 11;
   localparam int unsigned VCOUNT_W = 10;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DONE
   } fetch_state_t;

   // A band is fetched on the last raster line of the frame (band 0 for the next
   // frame) and on the last line of every group of S output lines, except for the
   // groups past the last source line.
   function automatic logic is_fetch_line(input logic [VCOUNT_W-1:0] vcount,
                                          input int unsigned         total_lines,
                                          input int unsigned         src_height,
                                          input int unsigned         scale_log2);
      int unsigned         s;
      logic [VCOUNT_W-1:0] mask;
      s    = 32'd1 << scale_log2;
      mask = VCOUNT_W'(s - 1);
      return (vcount == VCOUNT_W'(total_lines - 1)) ||
             ((32'(vcount) < (src_height - 1) * s) && ((vcount & mask) == mask));
   endfunction

endpackage

// File: rtl/kernel_raster_fetch.sv
// -----------------------------------------------------------------------------
// kernel_raster_fetch
// KxK column-raster fetch engine: walks (SRC_WIDTH+K-1) columns of K rows each,
// handing one address per beat to the filter under a valid/ready handshake.
// Optional build macro: UPSCALE_SCHED_CLAMP_EN replicates tile edges instead of
// reading the halo past them.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_hzero               hcount == 0
//   i_fetch_line          current raster line starts a band fetch
//   i_line_last           hcount == TOTAL_PIXELS-1
//   i_ready               filter accepts the current beat
//   i_h_base, i_v_base    tile x origin, current band y origin
//   i_v_off               tile y origin of this frame
//   o_valid               beat valid
//   o_haddr, o_vaddr      beat address (0 while not fetching)
//   o_overrun_set         line wrapped with the fetch still running
// -----------------------------------------------------------------------------
module kernel_raster_fetch
   import upscale_pkg::*;
#(
   parameter int unsigned SRC_WIDTH  = 128,
   parameter int unsigned SRC_HEIGHT = 128,
   parameter int unsigned KERNEL     = 3
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_hzero,
   input  logic                i_fetch_line,
   input  logic                i_line_last,
   input  logic                i_ready,
   input  logic [HCOUNT_W-1:0] i_h_base,
   input  logic [VCOUNT_W-1:0] i_v_base,
   input  logic [VCOUNT_W-1:0] i_v_off,
   output logic                o_valid,
   output logic [HCOUNT_W-1:0] o_haddr,
   output logic [VCOUNT_W-1:0] o_vaddr,
   output logic                o_overrun_set
);

   localparam int unsigned    NCOLS    = SRC_WIDTH + KERNEL - 1;
   localparam int unsigned    COL_W    = (NCOLS > 1) ? $clog2(NCOLS) : 1;
   localparam int unsigned    R_W      = (KERNEL > 1) ? $clog2(KERNEL) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(NCOLS - 1);
   localparam logic [R_W-1:0]   R_LAST   = R_W'(KERNEL - 1);
`ifdef UPSCALE_SCHED_CLAMP_EN
   localparam int HALF  = int'((KERNEL - 1) / 2);
   localparam int W_MAX = int'(SRC_WIDTH) - 1;
   localparam int H_MAX = int'(SRC_HEIGHT) - 1;
`endif

   fetch_state_t        r_state, w_state_d;
   logic [COL_W-1:0]    r_col, w_col_d;
   logic [R_W-1:0]      r_r, w_r_d;
   logic [VCOUNT_W-1:0] w_band;
   int                  w_col_idx;
   int                  w_row_idx;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_col   <= '0;
         r_r     <= '0;
      end else begin
         r_state <= w_state_d;
         r_col   <= w_col_d;
         r_r     <= w_r_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_col_d   = r_col;
      w_r_d     = r_r;
      unique case (r_state)
         IDLE: begin
         end
         FETCH: begin
            if (i_ready) begin
               if (r_r == R_LAST) begin
                  w_r_d = '0;
                  if (r_col == COL_LAST) begin
                     w_state_d = DONE;
                  end else begin
                     w_col_d = r_col + COL_W'(1);
                  end
               end else begin
                  w_r_d = r_r + R_W'(1);
               end
            end
         end
         DONE: begin
            if (i_line_last) begin
               w_state_d = IDLE;
            end
         end
         default: w_state_d = IDLE;
      endcase
      // Line start wins over the beat: a fetch still running at the wrap is
      // abandoned and restarted from column 0 with whatever band is current.
      if (i_hzero && (i_fetch_line || (r_state == FETCH))) begin
         w_state_d = FETCH;
         w_col_d   = '0;
         w_r_d     = '0;
      end
   end

   assign o_valid       = (r_state == FETCH);
   assign o_overrun_set = i_hzero && (r_state == FETCH);

   // Rows are indexed relative to the tile origin so clamping works on plain
   // integers; without clamping v_off + band + r equals v_base + r modulo 2^10.
   assign w_band = i_v_base - i_v_off;

   always_comb begin
      w_col_idx = int'(r_col);
      w_row_idx = int'(w_band) + int'(r_r);
`ifdef UPSCALE_SCHED_CLAMP_EN
      w_col_idx = w_col_idx - HALF;
      w_row_idx = w_row_idx - HALF;
      if (w_col_idx < 0) begin
         w_col_idx = 0;
      end else if (w_col_idx > W_MAX) begin
         w_col_idx = W_MAX;
      end
      if (w_row_idx < 0) begin
         w_row_idx = 0;
      end else if (w_row_idx > H_MAX) begin
         w_row_idx = H_MAX;
      end
`endif
   end

   assign o_haddr = o_valid ? (i_h_base + HCOUNT_W'(w_col_idx)) : '0;
   assign o_vaddr = o_valid ? (i_v_off + VCOUNT_W'(w_row_idx)) : '0;

endmodule

// File: rtl/upscale_sched_gen.sv
// -----------------------------------------------------------------------------
// upscale_sched_gen
// Frame-timing scheduler for the upscale path, driven by the raster counters.
// Produces a KxK column-raster fetch stream into the filter and a registered
// scaled read of the filtered line buffer. Scale S = 1<<SCALE_LOG2.
// Optional build macro: UPSCALE_SCHED_CLAMP_EN (edge-replicated fetch addresses).
// Ports:
//   clk_in, rst_n_in                     pixel clock, async active-low reset
//   h_offset_in, v_offset_in             tile origin, latched at frame start
//   hcount_in, vcount_in                 raster position
//   filt_ready_in                        filter accepts the fetch beat
//   hcount_filter_out, vcount_filter_out fetch address
//   valid_filter_out                     fetch beat valid
//   frame_rst_out                        1-cycle new-frame pulse
//   hcount_upscale_out                   filtered-buffer column
//   vcount_upscale_out                   output row
//   valid_upscale_out                    upscale read valid
//   overrun_out                          sticky fetch overrun, cleared per frame
// -----------------------------------------------------------------------------
module upscale_sched_gen
   import upscale_pkg::*;
#(
   parameter int unsigned TOTAL_PIXELS     = 1650,
   parameter int unsigned TOTAL_LINES      = 750,
   parameter int unsigned SRC_WIDTH        = 128,
   parameter int unsigned SRC_HEIGHT       = 128,
   parameter int unsigned SCALE_LOG2       = 2,
   parameter int unsigned KERNEL           = 3,
   parameter int unsigned START_UPSAMPLING = 1024
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic [HCOUNT_W-1:0] h_offset_in,
   input  logic [VCOUNT_W-1:0] v_offset_in,
   input  logic [HCOUNT_W-1:0] hcount_in,
   input  logic [VCOUNT_W-1:0] vcount_in,
   input  logic                filt_ready_in,
   output logic [HCOUNT_W-1:0] hcount_filter_out,
   output logic [VCOUNT_W-1:0] vcount_filter_out,
   output logic                valid_filter_out,
   output logic                frame_rst_out,
   output logic [HCOUNT_W-1:0] hcount_upscale_out,
   output logic [VCOUNT_W-1:0] vcount_upscale_out,
   output logic                valid_upscale_out,
   output logic                overrun_out
);

   localparam int unsigned WIN_LEN = SRC_WIDTH << SCALE_LOG2;

   if (START_UPSAMPLING + WIN_LEN > TOTAL_PIXELS) begin : g_chk_window
      $error("upscale read window runs past the end of the line");
   end
   if (SRC_HEIGHT * (32'd1 << SCALE_LOG2) > TOTAL_LINES) begin : g_chk_height
      $error("scaled tile height exceeds the frame");
   end
   if ((SCALE_LOG2 < 1) || (SCALE_LOG2 > 3)) begin : g_chk_scale
      $error("SCALE_LOG2 must be 1..3");
   end
   if ((KERNEL < 1) || (KERNEL > 7) || ((KERNEL % 2) == 0)) begin : g_chk_kernel
      $error("KERNEL must be odd and 1..7");
   end

   logic                w_fetch_line;
   logic                w_hzero;
   logic                w_frame_start;
   logic                w_line_last;
   logic                w_overrun_set;
   logic [HCOUNT_W:0]   w_win;
   logic                w_in_win;
   logic [HCOUNT_W-1:0] w_up_col;
   logic [VCOUNT_W-1:0] w_up_base;
   logic [VCOUNT_W-1:0] w_up_row;

   logic [HCOUNT_W-1:0] r_h_base;
   logic [VCOUNT_W-1:0] r_v_base;
   logic [VCOUNT_W-1:0] r_v_off;
   logic                r_frame_rst;
   logic                r_overrun;
   logic [HCOUNT_W-1:0] r_up_col;
   logic [VCOUNT_W-1:0] r_up_row;
   logic                r_up_valid;

   assign w_fetch_line  = is_fetch_line(vcount_in, TOTAL_LINES, SRC_HEIGHT, SCALE_LOG2);
   assign w_hzero       = (hcount_in == '0);
   assign w_frame_start = w_hzero && (vcount_in == VCOUNT_W'(TOTAL_LINES - 1));
   assign w_line_last   = (hcount_in == HCOUNT_W'(TOTAL_PIXELS - 1));

   // Window offset is one bit wider so hcount below the window start cannot
   // alias into range after the subtraction.
   assign w_win     = {1'b0, hcount_in} - (HCOUNT_W + 1)'(START_UPSAMPLING);
   assign w_in_win  = w_fetch_line && (hcount_in >= HCOUNT_W'(START_UPSAMPLING)) &&
                      (w_win < (HCOUNT_W + 1)'(WIN_LEN));
   assign w_up_col  = HCOUNT_W'(w_win >> SCALE_LOG2);
   assign w_up_base = (vcount_in == VCOUNT_W'(TOTAL_LINES - 1)) ? '0
                                                                 : vcount_in + VCOUNT_W'(1);
   assign w_up_row  = w_up_base + VCOUNT_W'(w_win[SCALE_LOG2-1:0]);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_h_base    <= '0;
         r_v_base    <= '0;
         r_v_off     <= '0;
         r_frame_rst <= 1'b0;
         r_overrun   <= 1'b0;
         r_up_col    <= '0;
         r_up_row    <= '0;
         r_up_valid  <= 1'b0;
      end else begin
         r_frame_rst <= w_frame_start;
         if (w_frame_start) begin
            r_h_base <= h_offset_in;
            r_v_base <= v_offset_in;
            r_v_off  <= v_offset_in;
         end else if (w_hzero && w_fetch_line) begin
            r_v_base <= r_v_base + VCOUNT_W'(1);
         end
         // An overrun detected on the frame-start wrap still gets reported.
         if (w_overrun_set) begin
            r_overrun <= 1'b1;
         end else if (w_frame_start) begin
            r_overrun <= 1'b0;
         end
         r_up_valid <= w_in_win;
         if (w_in_win) begin
            r_up_col <= w_up_col;
            r_up_row <= w_up_row;
         end
      end
   end

   kernel_raster_fetch #(
      .SRC_WIDTH  (SRC_WIDTH),
      .SRC_HEIGHT (SRC_HEIGHT),
      .KERNEL     (KERNEL)
   ) u_fetch (
      .i_clk         (clk_in),
      .i_rst_n       (rst_n_in),
      .i_hzero       (w_hzero),
      .i_fetch_line  (w_fetch_line),
      .i_line_last   (w_line_last),
      .i_ready       (filt_ready_in),
      .i_h_base      (r_h_base),
      .i_v_base      (r_v_base),
      .i_v_off       (r_v_off),
      .o_valid       (valid_filter_out),
      .o_haddr       (hcount_filter_out),
      .o_vaddr       (vcount_filter_out),
      .o_overrun_set (w_overrun_set)
   );

   assign frame_rst_out      = r_frame_rst;
   assign overrun_out        = r_overrun;
   assign hcount_upscale_out = r_up_col;
   assign vcount_upscale_out = r_up_row;
   assign valid_upscale_out  = r_up_valid;

endmodule
